// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and table sizing.
package truth_table_sweeper_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Number of entries in the exhaustive vector space for n_in inputs.
    function automatic int unsigned table_size(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold-cycle counter: pulses tick on the cycle its count reaches HOLD-1, then wraps to 0.
module sweep_hold_timer #(
    parameter int unsigned HOLD = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [CntW-1:0] cnt_q;

    assign tick = en && (cnt_q == CntW'(HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector, samples the DUT after each hold
// and scores the result against the EXPECTED truth table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned                       N_IN     = 3,
    parameter int unsigned                       HOLD     = 20,
    parameter logic [table_size(N_IN)-1:0]       EXPECTED = 8'b1110_1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec,
    input  logic            dut_z,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            sample_valid,
    output logic [N_IN-1:0] sample_idx,
    output logic            sample_ok,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            sv_q, sv_d;
    logic [N_IN-1:0] sidx_q, sidx_d;
    logic            sok_q, sok_d;
    logic [N_IN:0]   err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffi_q, ffi_d;

    logic tick;
    logic timer_en;
    logic timer_clr;
    logic hit;

    // Abort suppresses the tick so an aborted vector never produces a sample.
    assign timer_en  = (state_q == StRun) && !abort;
    assign timer_clr = (state_q != StRun) || abort;
    assign hit       = (dut_z == EXPECTED[vec_q]);

    sweep_hold_timer #(
        .HOLD(HOLD)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (timer_clr),
        .en   (timer_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        sv_d    = 1'b0;
        sidx_d  = sidx_q;
        sok_d   = sok_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffi_d   = ffi_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    vec_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffi_d   = '0;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    vec_d   = '0;
                end else if (tick) begin
                    sv_d   = 1'b1;
                    sidx_d = vec_q;
                    sok_d  = hit;
                    if (!hit) begin
                        err_d = err_q + {{N_IN{1'b0}}, 1'b1};
                        if (!ffv_q) begin
                            ffv_d = 1'b1;
                            ffi_d = vec_q;
                        end
                    end
                    if (vec_q == {N_IN{1'b1}}) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            sv_q    <= 1'b0;
            sidx_q  <= '0;
            sok_q   <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            sv_q    <= sv_d;
            sidx_q  <= sidx_d;
            sok_q   <= sok_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign sample_valid     = sv_q;
    assign sample_idx       = sidx_q;
    assign sample_ok        = sok_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule
